// File: rtl/spi_slave_interface.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by the system clock.
// Bridges an external SPI master to a byte-wide host (data_in/new_byte, data_out/send_complete).
module spi_slave_interface (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_clk,
  input  logic       slave_sel,
  input  logic       mosi,
  input  logic       new_byte,
  input  logic [7:0] data_in,
  output logic       miso,
  output logic       send_complete,
  output logic [7:0] data_out
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state, state_next;
  logic [2:0] sclk_sync;   // [0],[1] synchroniser, [2] previous value for edge detect
  logic [1:0] sel_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;
  logic       pending;

  logic sclk_rise, sclk_fall, sel_low, frame_start, frame_abort, active, tx_load;

  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign sel_low     = ~sel_sync[1];
  assign frame_start = (state == IDLE) && sel_low;
  assign frame_abort = (state == ACTIVE) && !sel_low;
  assign active      = (state == ACTIVE) && sel_low;
  // A fall with bit_cnt==0 while active means a byte just finished: preload the next one.
  assign tx_load     = frame_start || (active && sclk_fall && (bit_cnt == 3'd0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      sel_sync  <= 2'b11;   // come out of reset deselected
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], s_clk};
      sel_sync  <= {sel_sync[0], slave_sel};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_low)  state_next = ACTIVE;
      ACTIVE:  if (!sel_low) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miso = 1'b0;
    if (state == ACTIVE) miso = tx_shift[7];
  end

  // NOTE: the shift/holding registers are plain flops, so they are reset along with the control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= 8'h00;
      tx_hold  <= 8'h00;
      pending  <= 1'b0;
    end else if (tx_load) begin
      if (new_byte)     tx_shift <= data_in;
      else if (pending) tx_shift <= tx_hold;
      else              tx_shift <= 8'h00;
      pending <= 1'b0;
    end else begin
      if (new_byte) begin
        tx_hold <= data_in;
        pending <= 1'b1;
      end
      if (active && sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt       <= 3'd0;
      rx_shift      <= 8'h00;
      data_out      <= 8'h00;
      send_complete <= 1'b0;
    end else begin
      send_complete <= 1'b0;
      if (frame_start || frame_abort) begin
        bit_cnt <= 3'd0;
      end else if (active && sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_sync[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_out      <= {rx_shift[6:0], mosi_sync[1]};
          send_complete <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface: a bit-banged SPI master plus a
// scoreboard of expected received bytes popped on each send_complete pulse.
module tb_spi_slave_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_clk;
  logic       slave_sel;
  logic       mosi;
  logic       new_byte;
  logic [7:0] data_in;
  logic       miso;
  logic       send_complete;
  logic [7:0] data_out;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] exp_q[$];

  spi_slave_interface dut (
    .clk(clk), .reset(reset), .s_clk(s_clk), .slave_sel(slave_sel), .mosi(mosi),
    .new_byte(new_byte), .data_in(data_in), .miso(miso),
    .send_complete(send_complete), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Scoreboard: every send_complete pulse must match the oldest expected byte.
  always @(negedge clk) begin : sb_monitor
    logic [7:0] e;
    if (send_complete === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: data_out=%02h, no byte expected", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          fails++;
          $display("FAIL sb_data_out: got %02h expected %02h", data_out, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] b);
    data_in  = b;
    new_byte = 1'b1;
    tick(1);
    new_byte = 1'b0;
  endtask

  task automatic select_slave();
    slave_sel = 1'b0;
    tick(4);
  endtask

  task automatic deselect_slave();
    tick(4);
    slave_sel = 1'b1;
    tick(4);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Full 8-bit exchange; master samples miso just before each rise.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_miso);
    logic [7:0] got;
    logic       exp_sc;
    exp_q.push_back(tx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(4);
      got[i] = miso;
      s_clk  = 1'b1;
      if (i == 0) begin
        for (int k = 1; k <= 4; k++) begin
          tick(1);
          exp_sc = (k == 3);
          checks++;
          if (send_complete !== exp_sc) begin
            fails++;
            $display("FAIL pulse_timing: cycle %0d after rise send_complete=%b expected %b",
                     k, send_complete, exp_sc);
          end
        end
      end else begin
        tick(4);
      end
      s_clk = 1'b0;
    end
    check_val("miso_byte", got, exp_miso);
  endtask

  task automatic partial(input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      tick(4);
      s_clk = 1'b1;
      tick(4);
      s_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_clk = 1'b0; slave_sel = 1'b1; mosi = 1'b0;
    new_byte = 1'b0; data_in = 8'h00;
    tick(3);
    check_val("reset_miso", {7'd0, miso}, 8'h00);
    check_val("reset_send_complete", {7'd0, send_complete}, 8'h00);
    check_val("reset_data_out", data_out, 8'h00);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    load_byte(8'hA5);
    select_slave();
    xfer(8'h3C, 8'hA5);
    deselect_slave();
    check_val("basic_data_hold", data_out, 8'h3C);
    check_val("basic_miso_idle", {7'd0, miso}, 8'h00);
  endtask

  task automatic test_back_to_back();
    load_byte(8'h81);
    select_slave();
    load_byte(8'h7E);
    xfer(8'hFF, 8'h81);
    xfer(8'h00, 8'h7E);
    deselect_slave();
    check_val("b2b_data_out", data_out, 8'h00);
  endtask

  task automatic test_no_new_byte();
    select_slave();
    xfer(8'hC3, 8'h00);
    deselect_slave();
    check_val("nonew_data_out", data_out, 8'hC3);
  endtask

  task automatic test_abort();
    select_slave();
    partial(8'h96, 5);
    deselect_slave();
    check_val("abort_data_hold", data_out, 8'hC3);
    load_byte(8'hE7);
    select_slave();
    xfer(8'h5A, 8'hE7);
    deselect_slave();
    check_val("abort_next_frame", data_out, 8'h5A);
  endtask

  task automatic test_idle_sclk();
    slave_sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mosi  = 1'($urandom_range(0, 1));
      s_clk = 1'b1;
      tick(4);
      check_val("idle_miso_high", {7'd0, miso}, 8'h00);
      s_clk = 1'b0;
      tick(4);
      check_val("idle_miso_low", {7'd0, miso}, 8'h00);
    end
    tick(4);
    check_val("idle_data_hold", data_out, 8'h5A);
  endtask

  task automatic test_reset_mid();
    load_byte(8'h11);
    select_slave();
    load_byte(8'h99);
    partial(8'hF0, 3);
    tick(4);
    check_val("mid_miso_before_reset", {7'd0, miso}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check_val("mid_reset_miso", {7'd0, miso}, 8'h00);
    check_val("mid_reset_send_complete", {7'd0, send_complete}, 8'h00);
    check_val("mid_reset_data_out", data_out, 8'h00);
    s_clk = 1'b0;
    slave_sel = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    select_slave();
    xfer(8'hA6, 8'h00);
    deselect_slave();
    check_val("post_reset_data_out", data_out, 8'hA6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_new_byte();
    test_abort();
    test_idle_sclk();
    test_reset_mid();
    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: %0d expected bytes never completed", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
